// File: rtl/mem_a_rd_sched.sv
// A-matrix read scheduler: replays each row of A M times as (i,j,k)-tagged elements into a 2-entry output FIFO.
// Latency 2 cycles RUN->a_valid; reads issue only while FIFO + in-flight stays <= 2, so a_ready stalls never overflow it.
module mem_a_rd_sched #(
    parameter int N = 2,
    parameter int P = 4,
    parameter int M = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        wrA_done,
    input  logic        start,
    output logic [7:0]  addrbA,
    input  logic [31:0] doutbA,
    output logic [31:0] a_data,
    output logic [7:0]  a_row,
    output logic [7:0]  a_col,
    output logic [7:0]  a_k,
    output logic        a_last_k,
    output logic        a_valid,
    input  logic        a_ready,
    output logic        busy,
    output logic        done
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] WAIT_WR = 2'd1;
    localparam logic [1:0] RUN     = 2'd2;
    localparam logic [1:0] DRAIN   = 2'd3;

    localparam logic [7:0] NM1 = 8'(N - 1);
    localparam logic [7:0] MM1 = 8'(M - 1);
    localparam logic [7:0] PM1 = 8'(P - 1);
    localparam logic [7:0] P8  = 8'(P);

    typedef struct packed {
        logic [31:0] data;
        logic [7:0]  row;
        logic [7:0]  col;
        logic [7:0]  k;
        logic        lastK;
    } entry_t;

    logic [1:0] state;
    logic [7:0] iCnt, jCnt, kCnt;
    logic       inFlight;
    logic [7:0] flI, flJ, flK;
    entry_t     fifoMem [2];
    logic       wrPtr, rdPtr;
    logic [1:0] count;

    logic       pop;
    logic       issue;
    logic       lastRead;
    logic [1:0] occAfter;
    entry_t     head;

    always_comb begin
        head     = fifoMem[rdPtr];
        a_valid  = (count != 2'd0);
        pop      = a_valid && a_ready;
        // Occupancy at the next edge, counting the in-flight read landing and this cycle's pop.
        occAfter = count + {1'b0, inFlight} - {1'b0, pop};
        issue    = (state == RUN) && (occAfter < 2'd2);
        lastRead = (iCnt == NM1) && (jCnt == MM1) && (kCnt == PM1);
    end

    assign a_data   = head.data;
    assign a_row    = head.row;
    assign a_col    = head.col;
    assign a_k      = head.k;
    assign a_last_k = head.lastK;
    assign busy     = (state != IDLE);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= IDLE;
            iCnt       <= '0;
            jCnt       <= '0;
            kCnt       <= '0;
            inFlight   <= 1'b0;
            flI        <= '0;
            flJ        <= '0;
            flK        <= '0;
            fifoMem[0] <= '0;
            fifoMem[1] <= '0;
            wrPtr      <= 1'b0;
            rdPtr      <= 1'b0;
            count      <= '0;
            addrbA     <= '0;
            done       <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    state <= WAIT_WR;
                    iCnt  <= '0;
                    jCnt  <= '0;
                    kCnt  <= '0;
                end
                WAIT_WR: if (wrA_done) state <= RUN;
                RUN:     if (issue && lastRead) state <= DRAIN;
                DRAIN: if (occAfter == 2'd0) begin
                    state <= IDLE;
                    done  <= 1'b1;
                end
                default: state <= IDLE;
            endcase

            inFlight <= issue;
            if (issue) begin
                addrbA <= iCnt * P8 + kCnt;
                flI    <= iCnt;
                flJ    <= jCnt;
                flK    <= kCnt;
                if (kCnt == PM1) begin
                    kCnt <= '0;
                    if (jCnt == MM1) begin
                        jCnt <= '0;
                        iCnt <= iCnt + 8'd1;
                    end else begin
                        jCnt <= jCnt + 8'd1;
                    end
                end else begin
                    kCnt <= kCnt + 8'd1;
                end
            end

            if (inFlight) begin
                fifoMem[wrPtr] <= {doutbA, flI, flJ, flK, (flK == PM1)};
                wrPtr          <= ~wrPtr;
            end
            if (pop) rdPtr <= ~rdPtr;
            count <= occAfter;
        end
    end

endmodule

// File: tb/tb_mem_a_rd_sched.sv
// Bench for mem_a_rd_sched: scenario tasks compare observed handshakes against a nested-loop reference of A replay.
// The A memory answers combinationally from the registered addrbA, so data is ready the cycle after the address.
module tb_mem_a_rd_sched;

    localparam int N = 2;
    localparam int P = 4;
    localparam int M = 3;
    localparam int TOTAL = N * M * P;

    logic        clk;
    logic        reset;
    logic        wrA_done;
    logic        start;
    logic [7:0]  addrbA;
    logic [31:0] doutbA;
    logic [31:0] a_data;
    logic [7:0]  a_row, a_col, a_k;
    logic        a_last_k;
    logic        a_valid;
    logic        a_ready;
    logic        busy;
    logic        done;

    logic [31:0] memA [256];
    assign doutbA = memA[addrbA];

    mem_a_rd_sched #(.N(N), .P(P), .M(M)) dut (
        .clk      (clk),
        .reset    (reset),
        .wrA_done (wrA_done),
        .start    (start),
        .addrbA   (addrbA),
        .doutbA   (doutbA),
        .a_data   (a_data),
        .a_row    (a_row),
        .a_col    (a_col),
        .a_k      (a_k),
        .a_last_k (a_last_k),
        .a_valid  (a_valid),
        .a_ready  (a_ready),
        .busy     (busy),
        .done     (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] d;
        logic [7:0]  i, j, k;
        logic        last;
        int          cyc;
    } hs_t;

    hs_t        hsQ [$];
    int         doneCyc [$];
    int         stallBad, busyBad, addrMoved, firstValid;
    logic [7:0] stallAddr;
    int         errors = 0;
    int         checks = 0;

    // Number of positions where the observed stream differs from the i/j/k nested-loop replay of memA.
    function automatic int seq_errors();
        int idx = 0;
        int bad = 0;
        for (int i = 0; i < N; i++)
            for (int j = 0; j < M; j++)
                for (int k = 0; k < P; k++) begin
                    if (idx >= hsQ.size()) bad++;
                    else if (hsQ[idx].d !== memA[i * P + k] || hsQ[idx].i !== 8'(i) ||
                             hsQ[idx].j !== 8'(j) || hsQ[idx].k !== 8'(k) ||
                             hsQ[idx].last !== (k == P - 1)) bad++;
                    idx++;
                end
        if (hsQ.size() > idx) bad += hsQ.size() - idx;
        return bad;
    endfunction

    // Drives one pass from a negedge and records handshakes, done pulses and stall behaviour.
    task automatic run_pass(input int readyPct, input int stallLen, input int startAgainAt,
                            input int wrDelay, input int abortAtHs);
        logic        prevStall = 1'b0;
        logic [31:0] pd = '0;
        logic [7:0]  pi = '0, pj = '0, pk = '0;
        logic [7:0]  addr0;
        logic        r;
        hs_t         h;
        hsQ.delete();
        doneCyc.delete();
        stallBad = 0; busyBad = 0; addrMoved = 0; firstValid = -1; stallAddr = '0;
        wrA_done = (wrDelay == 0);
        start    = 1'b1;
        addr0    = addrbA;
        for (int t = 1; t <= 600; t++) begin
            @(negedge clk);
            start = (t == startAgainAt);
            if (t == wrDelay) wrA_done = 1'b1;
            if (wrDelay > 0 && t == wrDelay + 5) wrA_done = 1'b0;
            if (t <= wrDelay + 1 && addrbA !== addr0) addrMoved++;
            if (doneCyc.size() == 0 && done !== 1'b1 && busy !== 1'b1) busyBad++;
            if (done === 1'b1) doneCyc.push_back(t);
            if (a_valid === 1'b1 && firstValid < 0) firstValid = t;
            if (prevStall && (a_valid !== 1'b1 || a_data !== pd || a_row !== pi ||
                              a_col !== pj || a_k !== pk)) stallBad++;
            if (firstValid >= 0 && t < firstValid + stallLen) begin
                r = 1'b0;
                if (t == firstValid + stallLen - 1) stallAddr = addrbA;
            end else begin
                r = ($urandom_range(99) < readyPct);
            end
            a_ready = r;
            if (a_valid === 1'b1 && r) begin
                h.d = a_data; h.i = a_row; h.j = a_col; h.k = a_k; h.last = a_last_k; h.cyc = t;
                hsQ.push_back(h);
            end
            prevStall = (a_valid === 1'b1) && !r;
            pd = a_data; pi = a_row; pj = a_col; pk = a_k;
            if (abortAtHs > 0 && hsQ.size() == abortAtHs) begin
                reset = 1'b0;
                return;
            end
            if (doneCyc.size() > 0 && t >= doneCyc[0] + 40) break;
        end
        start   = 1'b0;
        a_ready = 1'b0;
    endtask

    task automatic test_reset();
        checks++;
        if ({addrbA, a_data, a_row, a_col, a_k, a_last_k, a_valid, busy, done} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got addr=%0d data=%0d tags=%0d/%0d/%0d last=%b vld=%b busy=%b done=%b, want all 0",
                     addrbA, a_data, a_row, a_col, a_k, a_last_k, a_valid, busy, done);
        end
        reset = 1'b1;
        repeat (5) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || a_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_stays_idle: busy=%b a_valid=%b, want 0 0", busy, a_valid);
        end
    endtask

    task automatic test_back_to_back();
        int n;
        run_pass(100, 0, -1, 0, 0);
        n = seq_errors();
        checks++;
        if (n !== 0) begin errors++; $display("FAIL b2b_seq: mismatches=%0d (count %0d), want 0 (count %0d)", n, hsQ.size(), TOTAL); end
        checks++;
        if (firstValid !== 4) begin errors++; $display("FAIL b2b_latency: first a_valid at cycle %0d, want 4", firstValid); end
        if (hsQ.size() == TOTAL) begin
            checks++;
            if (hsQ[TOTAL-1].cyc - hsQ[0].cyc !== TOTAL - 1) begin
                errors++;
                $display("FAIL b2b_throughput: span %0d cycles, want %0d", hsQ[TOTAL-1].cyc - hsQ[0].cyc, TOTAL - 1);
            end
        end
        checks++;
        if (doneCyc.size() !== 1) begin errors++; $display("FAIL b2b_done_count: %0d pulses, want 1", doneCyc.size()); end
        else if (hsQ.size() > 0) begin
            checks++;
            if (doneCyc[0] !== hsQ[hsQ.size()-1].cyc + 1) begin
                errors++;
                $display("FAIL b2b_done_timing: done at %0d, want %0d", doneCyc[0], hsQ[hsQ.size()-1].cyc + 1);
            end
        end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL b2b_idle_after: busy=%b, want 0", busy); end
    endtask

    task automatic test_wr_wait();
        int n;
        run_pass(100, 0, -1, 10, 0);
        checks++;
        if (addrMoved !== 0) begin errors++; $display("FAIL wr_addr_before: %0d addr changes, want 0", addrMoved); end
        checks++;
        if (busyBad !== 0) begin errors++; $display("FAIL wr_busy: %0d cycles busy low mid-pass, want 0", busyBad); end
        checks++;
        if (firstValid !== 13) begin errors++; $display("FAIL wr_latency: first a_valid at %0d, want 13", firstValid); end
        n = seq_errors();
        checks++;
        if (n !== 0 || doneCyc.size() !== 1) begin
            errors++;
            $display("FAIL wr_complete: mismatches=%0d done=%0d, want 0 and 1", n, doneCyc.size());
        end
    endtask

    task automatic test_random();
        int n;
        for (int x = 0; x < 256; x++) memA[x] = $urandom;
        run_pass(50, 0, -1, 0, 0);
        n = seq_errors();
        checks++;
        if (n !== 0) begin errors++; $display("FAIL rand_seq: mismatches=%0d (count %0d), want 0 (count %0d)", n, hsQ.size(), TOTAL); end
        checks++;
        if (stallBad !== 0) begin errors++; $display("FAIL rand_stable: %0d unstable stall cycles, want 0", stallBad); end
        checks++;
        if (doneCyc.size() !== 1 || hsQ.size() == 0) begin
            errors++;
            $display("FAIL rand_done: %0d pulses, want 1", doneCyc.size());
        end else if (doneCyc[0] !== hsQ[hsQ.size()-1].cyc + 1) begin
            errors++;
            $display("FAIL rand_done: done at %0d, want %0d", doneCyc[0], hsQ[hsQ.size()-1].cyc + 1);
        end
        for (int x = 0; x < 256; x++) memA[x] = x;
    endtask

    task automatic test_stall();
        int n;
        run_pass(100, 20, -1, 0, 0);
        checks++;
        if (stallAddr !== 8'd1) begin errors++; $display("FAIL stall_reads: addrbA=%0d at stall end, want 1", stallAddr); end
        checks++;
        if (stallBad !== 0) begin errors++; $display("FAIL stall_hold: %0d unstable stall cycles, want 0", stallBad); end
        n = seq_errors();
        checks++;
        if (n !== 0) begin errors++; $display("FAIL stall_seq: mismatches=%0d, want 0", n); end
    endtask

    task automatic test_abort();
        int n;
        int spurious = 0;
        run_pass(100, 0, -1, 0, 10);
        @(negedge clk);
        checks++;
        if ({addrbA, a_data, a_row, a_col, a_k, a_last_k, a_valid, busy, done} !== '0) begin
            errors++;
            $display("FAIL abort_zero: addr=%0d data=%0d vld=%b busy=%b done=%b, want all 0",
                     addrbA, a_data, a_valid, busy, done);
        end
        reset   = 1'b1;
        a_ready = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (done !== 1'b0 || busy !== 1'b0) spurious++;
        end
        checks++;
        if (spurious !== 0) begin errors++; $display("FAIL abort_no_done: %0d cycles with done/busy, want 0", spurious); end
        run_pass(100, 0, -1, 0, 0);
        n = seq_errors();
        checks++;
        if (n !== 0 || doneCyc.size() !== 1) begin
            errors++;
            $display("FAIL abort_replay: mismatches=%0d done=%0d, want 0 and 1", n, doneCyc.size());
        end
    endtask

    task automatic test_start_ignored();
        checks++;
        run_pass(100, 0, 8, 0, 0);
        if (hsQ.size() !== TOTAL || doneCyc.size() !== 1) begin
            errors++;
            $display("FAIL start_ignored: %0d elements %0d done pulses, want %0d and 1", hsQ.size(), doneCyc.size(), TOTAL);
        end
    endtask

    initial begin
        reset    = 1'b0;
        start    = 1'b0;
        wrA_done = 1'b0;
        a_ready  = 1'b0;
        for (int x = 0; x < 256; x++) memA[x] = x;
        repeat (3) @(negedge clk);
        test_reset();
        test_back_to_back();
        test_wr_wait();
        test_random();
        test_stall();
        test_abort();
        test_start_ignored();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_a_rd_sched.md
MEM_A_RD_SCHED -- requirements
Module: mem_a_rd_sched

Interface
REQ-001 Parameter N, default 2, number of rows of matrix A.
REQ-002 Parameter P, default 4, number of columns of A, which is the inner dimension.
REQ-003 Parameter M, default 3, number of columns of B, which is the number of times each A row is replayed.
REQ-004 clk  in  1  single clock; all state SHALL update on posedge clk only.
REQ-005 reset  in  1  synchronous, active-low reset: state SHALL clear on any posedge clk where reset==0.
REQ-006 wrA_done  in  1  level from the A-memory writer; high means A is fully loaded.
REQ-007 start  in  1  one-cycle pulse requesting one full A-stream pass.
REQ-008 addrbA  out  8  read address to the A-memory read port.
REQ-009 doutbA  in  32  A-memory read data, valid exactly 1 cycle after addrbA is presented.
REQ-010 a_data  out  32  streamed A element.
REQ-011 a_row, a_col, a_k  out  8 each  tags i, j, k of the element.
REQ-012 a_last_k  out  1  high when a_k==P-1, marking the end of one dot product.
REQ-013 a_valid  out  1  a_data and its tags are valid.
REQ-014 a_ready  in  1  consumer accepts the element when a_valid && a_ready.
REQ-015 busy  out  1  high from start acceptance until the pass completes.
REQ-016 done  out  1  one-cycle pulse after the final element is accepted.

Function
REQ-017 States SHALL be IDLE, WAIT_WR, RUN, DRAIN.
- IDLE --start--> WAIT_WR.
- WAIT_WR --wrA_done==1--> RUN.
- RUN --last read issued--> DRAIN.
- DRAIN --buffer empty and no read in flight--> IDLE, pulsing done.
REQ-018 start SHALL be ignored in every state other than IDLE.
REQ-019 In IDLE, start && wrA_done on the same cycle SHALL go to WAIT_WR and then to RUN on the next cycle; no cycle is skipped beyond that.
REQ-020 Issue order SHALL be nested loops: i=0..N-1 outer, j=0..M-1 middle, k=0..P-1 inner, giving N*M*P reads per pass.
REQ-021 The read address SHALL be i*P+k, computed at 8 bits.
- N*P>256 is illegal and unsupported.
REQ-022 The tags i, j, k of each read SHALL travel with it through a 1-stage in-flight pipeline matching the memory latency.
REQ-023 The output buffer SHALL be a 2-entry FIFO of {data, i, j, k}.
REQ-024 A read SHALL be issued in a cycle only if (FIFO occupancy + in-flight reads) < 2, taking into account an output pop in the same cycle.
- The FIFO therefore never overflows.
- Throughput SHALL be 1 element/cycle when a_ready is held high.
REQ-025 Latency: with a_ready=1, the first a_valid SHALL rise 2 cycles after entering RUN (1 cycle address, 1 cycle memory).
REQ-026 a_valid SHALL hold, and a_data and the tags SHALL stay stable, while a_valid && !a_ready.
REQ-027 Simultaneous push and pop on a full FIFO SHALL be legal and SHALL keep occupancy unchanged.
REQ-028 Loop wrap: when k==P-1, k SHALL become 0 and j increments; when j==M-1 as well, j SHALL become 0 and i increments; the read with i==N-1, j==M-1, k==P-1 SHALL be the last.
REQ-029 If wrA_done falls during RUN or DRAIN, the controller SHALL ignore it and complete the pass.
REQ-030 addrbA SHALL hold its last value when no read is issued.
REQ-031 busy SHALL be 1 in WAIT_WR, RUN and DRAIN, and 0 in IDLE.
REQ-032 done SHALL pulse in the cycle after the final handshake and coincide with the return to IDLE.

Reset
REQ-033 On reset==0 at posedge clk the block SHALL set:
- state = IDLE
- FIFO empty, no read in flight
- addrbA=0, a_data=0, a_row=a_col=a_k=0
- a_valid=0, a_last_k=0, busy=0, done=0
REQ-034 Reset asserted mid-pass SHALL abort the pass with no done pulse; any in-flight read data SHALL be discarded.
REQ-035 After reset releases, the block SHALL remain in IDLE until the next start.

Verification
REQ-036 Memory preloaded with A[x]=x, wrA_done=1, start, a_ready=1 -> 24 elements back-to-back.
- Data sequence: 0,1,2,3 repeated 3 times, then 4,5,6,7 repeated 3 times.
- a_last_k on every 4th element.
- done exactly 1 cycle after the 24th handshake.
REQ-037 start with wrA_done=0, raising it after 10 cycles -> busy=1 throughout, no addrbA change before wrA_done, first a_valid 2 cycles after RUN entry.
REQ-038 Random a_ready (50%) -> same 24-element ordered sequence, no loss or duplication, a_data stable while stalled, FIFO occupancy never >2.
REQ-039 a_ready=0 for 20 cycles after the first valid -> at most 2 reads issued, a_valid held with data 0 and tags (0,0,0).
REQ-040 reset=0 at the 10th handshake -> all outputs zero next cycle, no done pulse; a subsequent start replays the full pass from element 0.
REQ-041 start pulsed during RUN -> ignored; exactly one pass and one done pulse.
